elixirchip_es1_spu_op_mac: RTL and testbench

Parametrised multiply-accumulate operator for the ES1 SPU datapath, the successor to the plain multiply op. Each accepted input is a signed product that can load, add to, or subtract from a wide internal accumulator. The result is arithmetic-shifted and either saturated or truncated to the output width. It shares the op family's cke / clear / valid conventions and slots into the same SPU operator lanes.

---
 rtl/elixirchip_es1_spu_pkg.sv | 35 +++
 rtl/elixirchip_es1_spu_op_mul.sv | 73 +++++++
 rtl/elixirchip_es1_spu_op_mac.sv | 205 ++++++++++++++++++++
 tb/tb_elixirchip_es1_spu_op_mac.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the ES1 SPU operator family: the MAC mode encoding
// and the signed saturation helper used by ops that clamp to a narrower width.
package elixirchip_es1_spu_pkg;

  // Per-beat accumulator update selected by s_mode.
  typedef enum logic [1:0] {
    MUL = 2'd0,  // load the product
    ADD = 2'd1,  // accumulate the product
    SUB = 2'd2,  // subtract the product
    NOP = 2'd3   // hold
  } mac_mode_t;

  // Widest value the saturate helper accepts; callers sign-extend into it.
  localparam int SAT_BITS = 64;

  // Clamp a signed value into the signed range of a 'bits'-wide result.
  // The result stays SAT_BITS wide so callers can detect clamping by comparing
  // against the input and then keep the low 'bits' bits.
  function automatic logic signed [SAT_BITS-1:0] saturate(
    input logic signed [SAT_BITS-1:0] value,
    input int                         bits
  );
    logic signed [SAT_BITS-1:0] hi;
    logic signed [SAT_BITS-1:0] lo;
    hi = (SAT_BITS'(1) <<< (bits - 1)) - SAT_BITS'(1);
    lo = -hi - SAT_BITS'(1);
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mul.sv
// Pipelined signed multiply op of the ES1 SPU family. The full-precision
// product is sign-extended (or truncated) to M_DATA_BITS, arithmetic-shifted
// and delayed by LATENCY registers; LATENCY=0 gives a combinational path.
module elixirchip_es1_spu_op_mul #(
  parameter int                     LATENCY      = 1,
  parameter int                     S_DATA0_BITS = 8,
  parameter int                     S_DATA1_BITS = 8,
  parameter int                     M_DATA_BITS  = 16,
  parameter int                     DATA_SHIFT   = 0,
  parameter logic [M_DATA_BITS-1:0] CLEAR_DATA   = '0,
  parameter bit                     USE_CLEAR    = 1'b1,
  parameter bit                     USE_VALID    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic                    s_clear,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data,
  output logic                    m_valid
);

  localparam int PROD_BITS = S_DATA0_BITS + S_DATA1_BITS;

  logic signed [PROD_BITS-1:0]   prod;
  logic signed [M_DATA_BITS-1:0] prod_ext;
  logic [M_DATA_BITS-1:0]        stage_in;
  logic                          clear;
  logic                          valid;

  assign clear    = USE_CLEAR ? s_clear : 1'b0;
  assign valid    = USE_VALID ? s_valid : 1'b1;
  assign prod     = $signed(s_data0) * $signed(s_data1);
  assign prod_ext = M_DATA_BITS'(prod);
  assign stage_in = clear ? CLEAR_DATA : (prod_ext >>> DATA_SHIFT);

  generate
    if (LATENCY == 0) begin : g_comb
      assign m_data  = stage_in;
      assign m_valid = valid;
    end else begin : g_pipe
      logic [M_DATA_BITS-1:0] data_q  [LATENCY];
      logic                   valid_q [LATENCY];

      // Shift product and valid down the pipeline on every enabled cycle.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          // NOTE: every stage is reset (not just the last) so in-flight beats are
          // really discarded; this is a short register chain, not a RAM.
          for (int i = 0; i < LATENCY; i++) begin
            data_q[i]  <= CLEAR_DATA;
            valid_q[i] <= 1'b0;
          end
        end else if (cke) begin
          // NOTE: non-blocking assignments let each stage read the previous
          // stage's old value, which is what makes this a shift register.
          data_q[0]  <= stage_in;
          valid_q[0] <= valid;
          for (int i = 1; i < LATENCY; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign m_data  = data_q[LATENCY-1];
      assign m_valid = valid_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_mac.sv
// Multiply-accumulate op of the ES1 SPU family. A LATENCY-2 deep product
// pipeline (with mode/clear/valid travelling alongside) feeds a single-cycle
// accumulator, followed by a shift + saturate/truncate output register.
module elixirchip_es1_spu_op_mac
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int                  LATENCY      = 3,
  parameter int                  S_DATA0_BITS = 8,
  parameter int                  S_DATA1_BITS = 8,
  parameter int                  ACC_BITS     = 24,
  parameter int                  M_DATA_BITS  = 16,
  parameter int                  DATA_SHIFT   = 0,
  parameter bit                  SATURATE     = 1'b1,
  parameter logic [ACC_BITS-1:0] CLEAR_DATA   = '0,
  parameter bit                  USE_CLEAR    = 1'b1,
  parameter bit                  USE_VALID    = 1'b1,
  parameter string               DEVICE       = "RTL",
  parameter string               SIMULATION   = "false",
  parameter string               DEBUG        = "false"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic [1:0]              s_mode,
  input  logic                    s_clear,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data,
  output logic                    m_valid,
  output logic                    m_overflow
);

  localparam int PIPE_DEPTH = LATENCY - 2;
  localparam int MSB        = ACC_BITS - 1;

  // Output register value after reset or clear, folded at elaboration.
  localparam logic signed [ACC_BITS-1:0] CLEAR_SHIFT = $signed(CLEAR_DATA) >>> DATA_SHIFT;
  localparam logic signed [SAT_BITS-1:0] CLEAR_SAT   = saturate(SAT_BITS'(CLEAR_SHIFT), M_DATA_BITS);
  localparam logic [M_DATA_BITS-1:0]     CLEAR_OUT   = SATURATE ? CLEAR_SAT[M_DATA_BITS-1:0]
                                                                : CLEAR_SHIFT[M_DATA_BITS-1:0];

  generate
    if (LATENCY < 2 || LATENCY > 6) begin : g_bad_latency
      $error("elixirchip_es1_spu_op_mac: LATENCY must be 2..6");
    end
    if (ACC_BITS < S_DATA0_BITS + S_DATA1_BITS || ACC_BITS > SAT_BITS || M_DATA_BITS > ACC_BITS) begin : g_bad_width
      $error("elixirchip_es1_spu_op_mac: need S_DATA0_BITS+S_DATA1_BITS <= ACC_BITS <= 64 and M_DATA_BITS <= ACC_BITS");
    end
    if ((SIMULATION != "true" && SIMULATION != "false") || (DEBUG != "true" && DEBUG != "false") || DEVICE == "") begin : g_bad_family
      $error("elixirchip_es1_spu_op_mac: bad DEVICE/SIMULATION/DEBUG");
    end
  endgenerate

  // Side-band that must stay aligned with the product through the pipeline.
  typedef struct packed {
    mac_mode_t mode;
    logic      clear;
    logic      valid;
  } ctrl_t;

  ctrl_t               ctrl_in;
  ctrl_t               ctrl_d;
  logic [ACC_BITS-1:0] prod_d;
  logic                prod_valid;

  assign ctrl_in.mode  = mac_mode_t'(s_mode);
  assign ctrl_in.clear = USE_CLEAR ? s_clear : 1'b0;
  assign ctrl_in.valid = USE_VALID ? s_valid : 1'b1;

  elixirchip_es1_spu_op_mul #(
    .LATENCY      (PIPE_DEPTH),
    .S_DATA0_BITS (S_DATA0_BITS),
    .S_DATA1_BITS (S_DATA1_BITS),
    .M_DATA_BITS  (ACC_BITS),
    .DATA_SHIFT   (0),
    .CLEAR_DATA   ('0),
    .USE_CLEAR    (1'b0),
    .USE_VALID    (1'b0)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .s_data0 (s_data0),
    .s_data1 (s_data1),
    .s_clear (1'b0),
    .s_valid (1'b1),
    .m_data  (prod_d),
    .m_valid (prod_valid)
  );

  generate
    if (PIPE_DEPTH == 0) begin : g_ctrl_bypass
      assign ctrl_d = ctrl_in;
    end else begin : g_ctrl_pipe
      ctrl_t ctrl_q [PIPE_DEPTH];

      // Delay mode/clear/valid by the same depth as the product pipeline.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DEPTH; i++) begin
            ctrl_q[i] <= '{mode: MUL, clear: 1'b0, valid: 1'b0};
          end
        end else if (cke) begin
          ctrl_q[0] <= ctrl_in;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            ctrl_q[i] <= ctrl_q[i-1];
          end
        end
      end

      assign ctrl_d = ctrl_q[PIPE_DEPTH-1];
    end
  endgenerate

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] p;
  logic signed [ACC_BITS-1:0] sum;
  logic signed [ACC_BITS-1:0] diff;
  logic signed [ACC_BITS-1:0] acc_next;
  logic                       wrap;
  logic                       acc_ovf;
  logic                       clear_q;
  logic                       valid_q;

  assign p    = $signed(prod_d);
  assign sum  = acc + p;
  assign diff = acc - p;

  // Next accumulator value and signed-wrap detection for the current beat.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is
    // inferred for the hold (NOP / !valid) cases.
    acc_next = acc;
    wrap     = 1'b0;
    if (ctrl_d.valid) begin
      case (ctrl_d.mode)
        MUL: acc_next = p;
        ADD: begin
          acc_next = sum;
          wrap     = (acc[MSB] == p[MSB]) && (sum[MSB] != acc[MSB]);
        end
        SUB: begin
          acc_next = diff;
          wrap     = (acc[MSB] != p[MSB]) && (diff[MSB] != acc[MSB]);
        end
        default: ;
      endcase
    end
  end

  // Accumulator register; clear outranks valid and drops the wrap flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= $signed(CLEAR_DATA);
      acc_ovf <= 1'b0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (cke) begin
      if (ctrl_d.clear) begin
        acc     <= $signed(CLEAR_DATA);
        acc_ovf <= 1'b0;
      end else begin
        acc     <= acc_next;
        acc_ovf <= acc_ovf | wrap;
      end
      clear_q <= ctrl_d.clear;
      valid_q <= ctrl_d.valid & prod_valid;
    end
  end

  logic signed [ACC_BITS-1:0]    shifted;
  logic signed [SAT_BITS-1:0]    shifted_ext;
  logic signed [SAT_BITS-1:0]    sat_val;
  logic [M_DATA_BITS-1:0]        out_val;
  logic                          clamp;

  assign shifted     = acc >>> DATA_SHIFT;
  assign shifted_ext = SAT_BITS'(shifted);
  assign sat_val     = saturate(shifted_ext, M_DATA_BITS);

  // Reduce the shifted accumulator to the output width.
  always_comb begin
    out_val = shifted[M_DATA_BITS-1:0];
    clamp   = 1'b0;
    if (SATURATE) begin
      out_val = sat_val[M_DATA_BITS-1:0];
      clamp   = (sat_val != shifted_ext);
    end
  end

  // Output register; tracks the accumulator every cycle, overflow is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_data     <= CLEAR_OUT;
      m_valid    <= 1'b0;
      m_overflow <= 1'b0;
    end else if (cke) begin
      m_data     <= out_val;
      m_valid    <= valid_q;
      m_overflow <= clear_q ? 1'b0 : (m_overflow | acc_ovf | clamp);
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mac.sv
// Scoreboard bench for elixirchip_es1_spu_op_mac. Three instances share the
// same stimulus: the default configuration, a LATENCY=2 / DATA_SHIFT=4 one,
// and a LATENCY=5 / ACC 16 / truncating one. An arithmetic model predicts the
// output after each consumed beat; a monitor pops and compares per cke edge.
module tb_elixirchip_es1_spu_op_mac;
  import elixirchip_es1_spu_pkg::*;

  localparam int N_INST = 3;

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        ovf;
  } exp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke     = 1'b0;
  logic [7:0]  s_data0 = '0;
  logic [7:0]  s_data1 = '0;
  logic [1:0]  s_mode  = '0;
  logic        s_clear = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] m_data     [N_INST];
  logic        m_valid    [N_INST];
  logic        m_overflow [N_INST];

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_mac #(
    .LATENCY(3), .ACC_BITS(24), .M_DATA_BITS(16), .DATA_SHIFT(0),
    .SATURATE(1'b1), .CLEAR_DATA(24'd123)
  ) u_mac0 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_mode(s_mode), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_overflow(m_overflow[0])
  );

  elixirchip_es1_spu_op_mac #(
    .LATENCY(2), .ACC_BITS(24), .M_DATA_BITS(16), .DATA_SHIFT(4),
    .SATURATE(1'b1), .CLEAR_DATA(24'd123)
  ) u_mac1 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_mode(s_mode), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_overflow(m_overflow[1])
  );

  elixirchip_es1_spu_op_mac #(
    .LATENCY(5), .ACC_BITS(16), .M_DATA_BITS(16), .DATA_SHIFT(0),
    .SATURATE(1'b0), .CLEAR_DATA(16'd0)
  ) u_mac2 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_mode(s_mode), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data[2]), .m_valid(m_valid[2]), .m_overflow(m_overflow[2])
  );

  // Per-instance configuration, mirrored from the parameter overrides above.
  function automatic int cfg_acc(input int i);
    return (i == 2) ? 16 : 24;
  endfunction
  function automatic int cfg_shift(input int i);
    return (i == 1) ? 4 : 0;
  endfunction
  function automatic bit cfg_sat(input int i);
    return (i != 2);
  endfunction
  function automatic longint cfg_clear(input int i);
    return (i == 2) ? 0 : 123;
  endfunction
  function automatic int cfg_lat(input int i);
    case (i)
      0:       return 3;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  longint acc_model [N_INST];
  bit     ovf_model [N_INST];
  exp_t   q0 [$];
  exp_t   q1 [$];
  exp_t   q2 [$];
  int     checks   = 0;
  int     failures = 0;
  bit     started  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%h) required=%0d (0x%h) t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Value shown on m_data for a given accumulator, plus whether it was clamped.
  task automatic out_of(input int i, input longint acc, output logic [15:0] val, output bit clamped);
    longint r;
    r       = acc >>> cfg_shift(i);
    clamped = 1'b0;
    if (cfg_sat(i)) begin
      if (r > 32767) begin
        r = 32767; clamped = 1'b1;
      end else if (r < -32768) begin
        r = -32768; clamped = 1'b1;
      end
    end
    val = r[15:0];
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Apply one consumed beat to instance i's model and queue the output it yields.
  task automatic model_beat(input int i, input int a, input int b, input mac_mode_t mode,
                            input bit clr, input bit vld);
    longint span, half, p, s;
    bit     wrapped, clamped;
    exp_t   e;
    span    = longint'(1) << cfg_acc(i);
    half    = span / 2;
    p       = longint'(a) * longint'(b);
    s       = acc_model[i];
    wrapped = 1'b0;
    if (clr) begin
      s = cfg_clear(i);
    end else if (vld) begin
      case (mode)
        MUL:     s = p;
        ADD:     s = acc_model[i] + p;
        SUB:     s = acc_model[i] - p;
        default: s = acc_model[i];
      endcase
    end
    if (s >= half || s < -half) begin
      wrapped = 1'b1;
      s = s & (span - 1);
      if (s >= half) s = s - span;
    end
    acc_model[i] = s;
    out_of(i, s, e.data, clamped);
    if (clr) ovf_model[i] = 1'b0;
    else     ovf_model[i] = ovf_model[i] | wrapped | clamped;
    e.valid = vld;
    e.ovf   = ovf_model[i];
    push_exp(i, e);
  endtask

  // Reset drops in-flight beats; the first LATENCY-1 outputs after it are idle.
  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < N_INST; i++) begin
      acc_model[i] = cfg_clear(i);
      ovf_model[i] = 1'b0;
      for (int k = 0; k < cfg_lat(i) - 1; k++) model_beat(i, 0, 0, NOP, 1'b0, 1'b0);
    end
  endtask

  task automatic beat(input int a, input int b, input mac_mode_t mode, input bit clr,
                      input bit vld, input bit en = 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cke     = en;
    s_data0 = 8'(a);
    s_data1 = 8'(b);
    s_mode  = mode;
    s_clear = clr;
    s_valid = vld;
    if (en) for (int i = 0; i < N_INST; i++) model_beat(i, a, b, mode, clr, vld);
  endtask

  task automatic do_reset(input bit en);
    @(negedge clk);
    reset_n = 1'b0;
    cke     = en;
    s_valid = 1'b1;
    s_clear = 1'b0;
    model_reset();
  endtask

  task automatic check_inst(input int i);
    exp_t e;
    bit   empty;
    case (i)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      checks++;
      failures++;
      $display("FAIL u_mac%0d scoreboard: output present but no expectation queued t=%0t", i, $time);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("u_mac%0d m_data", i), m_data[i], e.data);
      check($sformatf("u_mac%0d m_valid", i), 16'(m_valid[i]), 16'(e.valid));
      check($sformatf("u_mac%0d m_overflow", i), 16'(m_overflow[i]), 16'(e.ovf));
    end
  endtask

  // Monitor: after every edge, check reset state or pop the scoreboard.
  initial begin : monitor
    bit          rst_s, cke_s, clamped;
    logic [15:0] clr_out;
    wait (started);
    forever begin
      @(posedge clk);
      rst_s = reset_n;
      cke_s = cke;
      #1;
      for (int i = 0; i < N_INST; i++) begin
        if (!rst_s) begin
          out_of(i, cfg_clear(i), clr_out, clamped);
          check($sformatf("u_mac%0d reset m_data", i), m_data[i], clr_out);
          check($sformatf("u_mac%0d reset m_valid", i), 16'(m_valid[i]), 16'd0);
          check($sformatf("u_mac%0d reset m_overflow", i), 16'(m_overflow[i]), 16'd0);
        end else if (cke_s) begin
          check_inst(i);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int a, b;
    started = 1'b1;
    do_reset(1'b0);
    do_reset(1'b1);

    // Load, accumulate, subtract.
    beat(0, 0, NOP, 1'b1, 1'b0);
    beat(127, 127, MUL, 1'b0, 1'b1);
    beat(3, 4, ADD, 1'b0, 1'b1);
    beat(-7, 5, SUB, 1'b0, 1'b1);

    // Repeated large ADDs from clear reach the clamp and set sticky overflow.
    beat(0, 0, NOP, 1'b1, 1'b0);
    repeat (3) beat(-128, -128, ADD, 1'b0, 1'b1);
    beat(0, 0, NOP, 1'b0, 1'b0);

    // Clear mid-stream drops overflow, then ADD continues from CLEAR_DATA.
    beat(0, 0, NOP, 1'b1, 1'b0);
    beat(3, 4, ADD, 1'b0, 1'b1);

    // ADD stream with a two-cycle stall in the middle.
    beat(5, 6, ADD, 1'b0, 1'b1);
    beat(7, 8, ADD, 1'b0, 1'b1);
    beat(1, 2, ADD, 1'b0, 1'b1, 1'b0);
    beat(9, 9, SUB, 1'b1, 1'b1, 1'b0);
    beat(2, 3, ADD, 1'b0, 1'b1);
    beat(4, 4, ADD, 1'b0, 1'b1);

    // Invalid beat holds the accumulator; the next valid ADD continues.
    beat(99, 99, ADD, 1'b0, 1'b0);
    beat(1, 1, ADD, 1'b0, 1'b1);

    // Reset with two beats in flight.
    beat(10, 10, ADD, 1'b0, 1'b1);
    beat(11, 11, ADD, 1'b0, 1'b1);
    do_reset(1'b0);
    beat(0, 0, NOP, 1'b0, 1'b0);

    // Three 127*127 ADDs from clear: wraps in the 16-bit truncating instance.
    beat(0, 0, NOP, 1'b1, 1'b0);
    repeat (3) beat(127, 127, ADD, 1'b0, 1'b1);
    repeat (6) beat(0, 0, NOP, 1'b0, 1'b0);

    // Randomized traffic, including occasional resets under either cke.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset($urandom_range(1) == 1);
      end else begin
        a = int'($urandom_range(255)) - 128;
        b = int'($urandom_range(255)) - 128;
        beat(a, b, mac_mode_t'($urandom_range(3)), $urandom_range(19) == 0,
             $urandom_range(4) != 0, $urandom_range(6) != 0);
      end
    end
    repeat (8) beat(0, 0, NOP, 1'b0, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
